// File: rtl/innerproduct_mac_stream_pkg.sv
`default_nettype none
// ==========================================================================
// innerproduct_pkg : shared default widths, FSM states, sizing/clamp helpers
// Revision: 1.0
// ==========================================================================
package innerproduct_pkg;

   localparam int C_X_W        = 7;
   localparam int C_W_W        = 32;
   localparam int C_ACC_W      = 32;
   localparam int C_BIAS_SHIFT = 16;
   localparam int C_SAT_MAXW   = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_e;

   // Wide enough for the shifted bias plus every product, so the sum never wraps.
   function automatic int calc_int_w(input int x_w, input int w_w, input int bias_shift,
                                     input int n_feat);
      int bias_w;
      int prod_w;
      bias_w = w_w + bias_shift;
      prod_w = x_w + w_w + 1;
      return ((bias_w > prod_w) ? bias_w : prod_w) + $clog2(n_feat + 1) + 1;
   endfunction

   function automatic logic signed [C_SAT_MAXW-1:0] sat_clamp(
      input logic signed [C_SAT_MAXW-1:0] v,
      input int                           acc_w
   );
      logic signed [C_SAT_MAXW-1:0] hi;
      logic signed [C_SAT_MAXW-1:0] lo;
      hi = (C_SAT_MAXW'(1) << (acc_w - 1)) - C_SAT_MAXW'(1);
      lo = ~hi;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/innerproduct_mac_stream_weight_bank.sv
`default_nettype none
// ==========================================================================
// weight_bank : (N_FEAT+1) x W_W register file, one write port, LANES+bias reads
// Revision: 1.0
// ==========================================================================
module weight_bank
   import innerproduct_pkg::*;
#(
   parameter int N_FEAT = 80,
   parameter int LANES  = 1,
   parameter int W_W    = C_W_W,
   parameter int AW     = 7,
   parameter int BW     = 7
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we_i,
   input  logic [AW-1:0]             waddr_i,
   input  logic [W_W-1:0]            wdata_i,
   input  logic [BW-1:0]             beat_i,
   output logic [LANES-1:0][W_W-1:0] rd_data_o,
   output logic [W_W-1:0]            bias_o
);

   logic [W_W-1:0] mem_q [0:N_FEAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= N_FEAT; i++) mem_q[i] <= '0;
      end else if (we_i && (int'(waddr_i) <= N_FEAT)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_rd
         assign rd_data_o[k] = mem_q[AW'(int'(beat_i) * LANES + k + 1)];
      end
   endgenerate

   assign bias_o = mem_q[0];

endmodule
`default_nettype wire

// File: rtl/innerproduct_mac_stream.sv
`default_nettype none
// ==========================================================================
// innerproduct_mac_stream : streamed bias + sum(x[i]*w[i]) with loadable weights
// Revision: 1.0
// ==========================================================================
module innerproduct_mac_stream
   import innerproduct_pkg::*;
#(
   parameter int N_FEAT     = 80,
   parameter int LANES      = 1,
   parameter int X_W        = C_X_W,
   parameter int W_W        = C_W_W,
   parameter int ACC_W      = C_ACC_W,
   parameter int BIAS_SHIFT = C_BIAS_SHIFT,
   parameter bit SAT        = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear_i,
   input  logic                          w_we_i,
   input  logic [$clog2(N_FEAT+1)-1:0]   w_addr_i,
   input  logic [W_W-1:0]                w_data_i,
   output logic                          w_ready_o,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [LANES*X_W-1:0]          in_data_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [ACC_W-1:0]              out_data_o
);

   localparam int AW     = $clog2(N_FEAT + 1);
   localparam int NBEATS = N_FEAT / LANES;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int PW     = X_W + W_W + 1;
   localparam int INT_W  = calc_int_w(X_W, W_W, BIAS_SHIFT, N_FEAT);
   localparam logic [BW-1:0] C_LAST_BEAT = BW'(NBEATS - 1);

   state_e                    state_q, state_d;
   logic [BW-1:0]             beat_q, beat_d;
   logic                      pv_q, pv_d;
   logic                      first_q, first_d;
   logic                      last_q, last_d;
   logic [W_W-1:0]            bias_q, bias_d;
   logic [LANES-1:0][PW-1:0]  prod_q, prod_d;
   logic signed [INT_W-1:0]   acc_q, acc_d;

   logic [LANES-1:0][W_W-1:0] w_wt;
   logic [W_W-1:0]            w_bias;
   logic [LANES-1:0][PW-1:0]  w_prod;
   logic signed [INT_W-1:0]   w_lane_sum;
   logic signed [INT_W-1:0]   w_bias_term;
   logic                      w_beat_acc;
   logic                      w_write_acc;

   assign in_ready_o  = (state_q == IDLE) || (state_q == ACC);
   assign w_ready_o   = (state_q == IDLE);
   assign out_valid_o = (state_q == HOLD);
   assign w_beat_acc  = in_valid_i && in_ready_o && !clear_i;
   assign w_write_acc = w_we_i && w_ready_o;

   weight_bank #(
      .N_FEAT (N_FEAT),
      .LANES  (LANES),
      .W_W    (W_W),
      .AW     (AW),
      .BW     (BW)
   ) u_weight_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (w_write_acc),
      .waddr_i   (w_addr_i),
      .wdata_i   (w_data_i),
      .beat_i    (beat_q),
      .rd_data_o (w_wt),
      .bias_o    (w_bias)
   );

   always_comb begin
      w_prod = '0;
      for (int k = 0; k < LANES; k++) begin
         w_prod[k] = PW'($signed({1'b0, in_data_i[k*X_W +: X_W]})) * PW'($signed(w_wt[k]));
      end
   end

   always_comb begin
      w_lane_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         w_lane_sum = w_lane_sum + INT_W'($signed(prod_q[k]));
      end
   end

   assign w_bias_term = INT_W'($signed(bias_q)) <<< BIAS_SHIFT;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      pv_d    = w_beat_acc;
      first_d = first_q;
      last_d  = last_q;
      bias_d  = bias_q;
      prod_d  = prod_q;
      acc_d   = acc_q;

      // Bias is captured with the first beat so a same-cycle bias write is not seen.
      if (w_beat_acc) begin
         prod_d  = w_prod;
         first_d = (beat_q == '0);
         last_d  = (beat_q == C_LAST_BEAT);
         bias_d  = w_bias;
         beat_d  = (beat_q == C_LAST_BEAT) ? '0 : beat_q + 1'b1;
      end

      if (pv_q) acc_d = (first_q ? w_bias_term : acc_q) + w_lane_sum;

      case (state_q)
         IDLE:    if (w_beat_acc) state_d = (beat_q == C_LAST_BEAT) ? DRAIN : ACC;
         ACC:     if (w_beat_acc && (beat_q == C_LAST_BEAT)) state_d = DRAIN;
         DRAIN:   if (pv_q && last_q) state_d = HOLD;
         HOLD:    if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (clear_i) begin
         state_d = IDLE;
         beat_d  = '0;
         pv_d    = 1'b0;
         acc_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         pv_q    <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         bias_q  <= '0;
         prod_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         pv_q    <= pv_d;
         first_q <= first_d;
         last_q  <= last_d;
         bias_q  <= bias_d;
         prod_q  <= prod_d;
         acc_q   <= acc_d;
      end
   end

   generate
      if (SAT) begin : g_sat
         assign out_data_o = ACC_W'(sat_clamp(C_SAT_MAXW'(acc_q), ACC_W));
      end else begin : g_wrap
         assign out_data_o = ACC_W'(acc_q);
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_innerproduct_mac_stream.sv
`default_nettype none
// ==========================================================================
// tb_innerproduct_mac_stream : scoreboard bench, LANES=1/wrap and LANES=4/SAT16
// Revision: 1.0
// ==========================================================================
module tb_innerproduct_mac_stream;

   localparam int NF = 80;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        a_clear, a_we, a_wrdy, a_iv, a_ir, a_ov, a_or;
   logic [6:0]  a_addr;
   logic [31:0] a_wd;
   logic [6:0]  a_in;
   logic [31:0] a_out;

   logic        b_clear, b_we, b_wrdy, b_iv, b_ir, b_ov, b_or;
   logic [6:0]  b_addr;
   logic [31:0] b_wd;
   logic [27:0] b_in;
   logic [15:0] b_out;

   innerproduct_mac_stream dut_a (
      .clk(clk), .rst_n(rst_n), .clear_i(a_clear), .w_we_i(a_we), .w_addr_i(a_addr),
      .w_data_i(a_wd), .w_ready_o(a_wrdy), .in_valid_i(a_iv), .in_ready_o(a_ir),
      .in_data_i(a_in), .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_out)
   );

   innerproduct_mac_stream #(.LANES(4), .ACC_W(16), .SAT(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear_i(b_clear), .w_we_i(b_we), .w_addr_i(b_addr),
      .w_data_i(b_wd), .w_ready_o(b_wrdy), .in_valid_i(b_iv), .in_ready_o(b_ir),
      .in_data_i(b_in), .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_out)
   );

   longint      wa [0:NF];
   longint      wb [0:NF];
   int          xa [1:NF];
   int          xb [1:NF];
   logic [31:0] qa [$];
   logic [15:0] qb [$];
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic logic [31:0] model_a();
      longint s;
      s = wa[0] * 65536;
      for (int i = 1; i <= NF; i++) s += longint'(xa[i]) * wa[i];
      return 32'(s);
   endfunction

   function automatic logic [15:0] model_b();
      longint s;
      s = wb[0] * 65536;
      for (int i = 1; i <= NF; i++) s += longint'(xb[i]) * wb[i];
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   task automatic a_wr(input int addr, input longint data);
      a_we = 1'b1; a_addr = 7'(addr); a_wd = 32'(data);
      @(posedge clk); #1;
      a_we = 1'b0;
      if (addr <= NF) wa[addr] = data;
   endtask

   task automatic b_wr(input int addr, input longint data);
      b_we = 1'b1; b_addr = 7'(addr); b_wd = 32'(data);
      @(posedge clk); #1;
      b_we = 1'b0;
      if (addr <= NF) wb[addr] = data;
   endtask

   task automatic a_stream(input int nbeats, input bit push, input bit wr_en,
                           input int wr_addr, input longint wr_data);
      int guard;
      if (push) qa.push_back(model_a());
      for (int b = 0; b < nbeats; b++) begin
         guard = 0;
         a_iv = 1'b1; a_in = 7'(xa[b+1]);
         if (wr_en && b == 0) begin a_we = 1'b1; a_addr = 7'(wr_addr); a_wd = 32'(wr_data); end
         while (!a_ir && guard < 100) begin @(posedge clk); #1; guard++; end
         if (!a_ir) begin n_cmp++; n_err++; $display("FAIL a_in_ready_wait got %b want 1", a_ir); end
         @(posedge clk); #1;
         a_we = 1'b0;
      end
      a_iv = 1'b0;
      if (wr_en) wa[wr_addr] = wr_data;
   endtask

   task automatic b_stream(input int nbeats, input bit push);
      int guard;
      if (push) qb.push_back(model_b());
      for (int b = 0; b < nbeats; b++) begin
         guard = 0;
         b_iv = 1'b1;
         for (int k = 0; k < 4; k++) b_in[k*7 +: 7] = 7'(xb[b*4+k+1]);
         while (!b_ir && guard < 100) begin @(posedge clk); #1; guard++; end
         if (!b_ir) begin n_cmp++; n_err++; $display("FAIL b_in_ready_wait got %b want 1", b_ir); end
         @(posedge clk); #1;
      end
      b_iv = 1'b0;
   endtask

   task automatic a_drain(input string name);
      int guard;
      logic [31:0] e;
      guard = 0;
      while (!(a_ov && a_or) && guard < 100) begin @(posedge clk); #1; guard++; end
      n_cmp++;
      if (!(a_ov && a_or)) begin
         n_err++; $display("FAIL %s no_result out_valid got %b want 1", name, a_ov);
      end else if (qa.size() == 0) begin
         n_err++; $display("FAIL %s unexpected_result got %0d want none", name, $signed(a_out));
      end else begin
         e = qa.pop_front();
         if (a_out !== e) begin
            n_err++; $display("FAIL %s out_data got %0d want %0d", name, $signed(a_out), $signed(e));
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic b_drain(input string name);
      int guard;
      logic [15:0] e;
      guard = 0;
      while (!(b_ov && b_or) && guard < 100) begin @(posedge clk); #1; guard++; end
      n_cmp++;
      if (!(b_ov && b_or)) begin
         n_err++; $display("FAIL %s no_result out_valid got %b want 1", name, b_ov);
      end else if (qb.size() == 0) begin
         n_err++; $display("FAIL %s unexpected_result got %0d want none", name, $signed(b_out));
      end else begin
         e = qb.pop_front();
         if (b_out !== e) begin
            n_err++; $display("FAIL %s out_data got %0d want %0d", name, $signed(b_out), $signed(e));
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_clear = 0; a_we = 0; a_iv = 0; a_or = 1; a_addr = '0; a_wd = '0; a_in = '0;
      b_clear = 0; b_we = 0; b_iv = 0; b_or = 1; b_addr = '0; b_wd = '0; b_in = '0;
      for (int i = 0; i <= NF; i++) begin wa[i] = 0; wb[i] = 0; end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL rst_a_out_valid got %b want 0", a_ov); end
      n_cmp++; if (a_ir !== 1'b1) begin n_err++; $display("FAIL rst_a_in_ready got %b want 1", a_ir); end
      n_cmp++; if (a_wrdy !== 1'b1) begin n_err++; $display("FAIL rst_a_w_ready got %b want 1", a_wrdy); end
      n_cmp++; if (a_out !== 32'd0) begin n_err++; $display("FAIL rst_a_out_data got %0d want 0", a_out); end
      n_cmp++; if (b_ov !== 1'b0 || b_ir !== 1'b1) begin n_err++; $display("FAIL rst_b_flags got ov=%b ir=%b want 0/1", b_ov, b_ir); end
   endtask

   task automatic test_basic();
      a_wr(0, 1);
      for (int i = 1; i <= NF; i++) a_wr(i, i);
      a_wr(81, 777);
      for (int i = 1; i <= NF; i++) xa[i] = 1;
      a_or = 1'b1;
      a_stream(NF, 1'b1, 1'b0, 0, 0);
      n_cmp++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL basic_lat1 out_valid got %b want 0", a_ov); end
      n_cmp++; if (a_ir !== 1'b0) begin n_err++; $display("FAIL basic_drain_in_ready got %b want 0", a_ir); end
      @(posedge clk); #1;
      n_cmp++; if (a_ov !== 1'b1) begin n_err++; $display("FAIL basic_lat2 out_valid got %b want 1", a_ov); end
      a_drain("basic");
   endtask

   task automatic test_lanes4();
      b_wr(0, 0);
      for (int i = 1; i <= NF; i++) b_wr(i, -1);
      for (int i = 1; i <= NF; i++) xb[i] = 127;
      b_or = 1'b1;
      b_stream(NF / 4, 1'b1);
      n_cmp++; if (b_ir !== 1'b0) begin n_err++; $display("FAIL lanes4_in_ready_after_last got %b want 0", b_ir); end
      @(posedge clk); #1;
      n_cmp++; if (b_ov !== 1'b1 || b_ir !== 1'b0) begin n_err++; $display("FAIL lanes4_hold got ov=%b ir=%b want 1/0", b_ov, b_ir); end
      b_drain("lanes4");
   endtask

   task automatic test_saturation();
      for (int i = 1; i <= NF; i++) b_wr(i, 32767);
      b_stream(NF / 4, 1'b1);
      b_drain("sat_pos");
      for (int i = 1; i <= NF; i++) b_wr(i, -32768);
      b_stream(NF / 4, 1'b1);
      b_drain("sat_neg");
   endtask

   task automatic test_wrap();
      for (int i = 0; i <= NF; i++) a_wr(i, 64'sh7FFF_FFFF);
      for (int i = 1; i <= NF; i++) xa[i] = 127;
      a_stream(NF, 1'b1, 1'b0, 0, 0);
      a_drain("wrap");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i <= NF; i++) a_wr(i, longint'(int'($urandom)));
      for (int i = 1; i <= NF; i++) xa[i] = int'($urandom_range(0, 127));
      a_or = 1'b0;
      a_stream(NF, 1'b1, 1'b0, 0, 0);
      @(posedge clk); #1;
      for (int i = 1; i <= NF; i++) xa[i] = int'($urandom_range(0, 127));
      a_iv = 1'b1; a_in = 7'(xa[1]);
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (a_ov !== 1'b1 || a_ir !== 1'b0 || a_out !== qa[0]) begin
            n_err++; $display("FAIL b2b_hold c%0d got ov=%b ir=%b data=%0d want 1/0/%0d", c, a_ov, a_ir, $signed(a_out), $signed(qa[0]));
         end
         @(posedge clk); #1;
      end
      a_or = 1'b1;
      a_drain("b2b_first");
      a_stream(NF, 1'b1, 1'b0, 0, 0);
      a_drain("b2b_second");
   endtask

   task automatic test_same_cycle_write();
      for (int i = 1; i <= NF; i++) xa[i] = int'($urandom_range(0, 127));
      a_stream(NF, 1'b1, 1'b1, 0, 12345);
      a_drain("wr_first_beat_old_bias");
      a_stream(NF, 1'b1, 1'b0, 0, 0);
      a_drain("wr_first_beat_new_bias");
   endtask

   task automatic test_clear();
      for (int i = 1; i <= NF; i++) xa[i] = int'($urandom_range(0, 127));
      a_stream(40, 1'b0, 1'b0, 0, 0);
      a_we = 1'b1; a_addr = 7'd5; a_wd = 32'd999;
      n_cmp++; if (a_wrdy !== 1'b0) begin n_err++; $display("FAIL acc_w_ready got %b want 0", a_wrdy); end
      @(posedge clk); #1;
      a_we = 1'b0;
      a_clear = 1'b1; a_iv = 1'b1; a_in = 7'(xa[41]);
      @(posedge clk); #1;
      a_clear = 1'b0; a_iv = 1'b0;
      n_cmp++; if (a_ir !== 1'b1 || a_ov !== 1'b0 || a_wrdy !== 1'b1) begin
         n_err++; $display("FAIL clear_idle got ir=%b ov=%b wr=%b want 1/0/1", a_ir, a_ov, a_wrdy);
      end
      a_stream(NF, 1'b1, 1'b0, 0, 0);
      a_drain("after_clear");
   endtask

   task automatic test_rst_mid();
      a_stream(30, 1'b0, 1'b0, 0, 0);
      rst_n = 1'b0;
      #2;
      n_cmp++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid got %b want 0", a_ov); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (a_ir !== 1'b1 || a_ov !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags got ir=%b ov=%b want 1/0", a_ir, a_ov); end
      for (int i = 0; i <= NF; i++) begin wa[i] = 0; wb[i] = 0; end
      for (int i = 1; i <= NF; i++) xa[i] = int'($urandom_range(1, 127));
      a_stream(NF, 1'b1, 1'b0, 0, 0);
      a_drain("rst_mid_zero_weights");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lanes4();
      test_saturation();
      test_wrap();
      test_back_to_back();
      test_same_cycle_write();
      test_clear();
      test_rst_mid();
      n_cmp++;
      if (qa.size() != 0 || qb.size() != 0) begin
         n_err++; $display("FAIL leftover_results got %0d/%0d want 0/0", qa.size(), qb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
